// File: rtl/spi_flash_arbiter_if.sv
// rtl/spi_flash_arbiter_if.sv - requester, flash-pin and status signals of the SPI flash arbiter
interface spi_flash_arbiter_if;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [1:0] m_csel;
  logic [1:0] m_clk;
  logic [1:0] m_mosi;
  logic [1:0] m_miso;
  logic       flash_csel;
  logic       flash_clk;
  logic       flash_mosi;
  logic       flash_miso;
  logic       busy;
  logic       timeout;

  modport slave (
    input  req, m_csel, m_clk, m_mosi, flash_miso,
    output gnt, m_miso, flash_csel, flash_clk, flash_mosi, busy, timeout
  );

  modport master (
    output req, m_csel, m_clk, m_mosi, flash_miso,
    input  gnt, m_miso, flash_csel, flash_clk, flash_mosi, busy, timeout
  );
endinterface

// File: rtl/spi_flash_arbiter.sv
// rtl/spi_flash_arbiter.sv - two-port round-robin owner of the SPI flash pins with CS gap and hold watchdog
module spi_flash_arbiter #(
  parameter int CS_GAP_CYCLES   = 4,
  parameter int MAX_HOLD_CYCLES = 0,
  parameter int HOLD_WIDTH      = 24
) (
  input  logic                clk_48mhz,
  input  logic                resetn,
  spi_flash_arbiter_if.slave  bus
);

  localparam int GAP_LOAD = (CS_GAP_CYCLES < 1) ? 1 : CS_GAP_CYCLES;
  localparam int GAP_W    = $clog2(GAP_LOAD + 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_LOAD);
  localparam bit WDOG_EN = (MAX_HOLD_CYCLES != 0);
  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST =
      WDOG_EN ? HOLD_WIDTH'(MAX_HOLD_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  state_t                state;
  logic                  owner;
  logic                  last_owner;
  logic [1:0]            gnt_r;
  logic [1:0]            lockout;
  logic                  timeout_r;
  logic [GAP_W-1:0]      gap_cnt;
  logic [HOLD_WIDTH-1:0] hold_cnt;

  logic [1:0] eligible;
  logic       pick;
  logic       own;
  logic [1:0] miso_mux;

  assign eligible = bus.req & ~lockout;
  assign own      = (state == OWN);

  // On a tie the port that did not own the bus last time wins.
  always_comb begin
    pick = eligible[1];
    if (eligible == 2'b11) pick = ~last_owner;
  end

  always_ff @(posedge clk_48mhz) begin
    if (!resetn) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      gnt_r      <= 2'b00;
      lockout    <= 2'b00;
      timeout_r  <= 1'b0;
      gap_cnt    <= '0;
      hold_cnt   <= '0;
    end else begin
      timeout_r <= 1'b0;
      lockout   <= lockout & bus.req;
      case (state)
        IDLE: begin
          if (|eligible) begin
            owner      <= pick;
            last_owner <= pick;
            gnt_r      <= pick ? 2'b10 : 2'b01;
            hold_cnt   <= '0;
            state      <= OWN;
          end
        end
        OWN: begin
          hold_cnt <= hold_cnt + HOLD_WIDTH'(1);
          // A voluntary release takes priority over a coincident watchdog expiry.
          if (!bus.req[owner]) begin
            gnt_r   <= 2'b00;
            gap_cnt <= GAP_INIT;
            state   <= GAP;
          end else if (WDOG_EN && (hold_cnt == HOLD_LAST)) begin
            gnt_r          <= 2'b00;
            timeout_r      <= 1'b1;
            lockout[owner] <= 1'b1;
            gap_cnt        <= GAP_INIT;
            state          <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt <= GAP_W'(1)) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          gnt_r <= 2'b00;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    miso_mux = 2'b11;
    if (own) miso_mux[owner] = bus.flash_miso;
  end

  assign bus.flash_csel = own ? bus.m_csel[owner] : 1'b1;
  assign bus.flash_clk  = own ? bus.m_clk[owner]  : 1'b0;
  assign bus.flash_mosi = own ? bus.m_mosi[owner] : 1'b0;
  assign bus.m_miso     = miso_mux;
  assign bus.gnt        = gnt_r;
  assign bus.busy       = (state != IDLE);
  assign bus.timeout    = timeout_r;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb/tb_spi_flash_arbiter.sv - scoreboard bench running three arbiter configurations against one event model
module tb_spi_flash_arbiter;

  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] req;
  logic [1:0] m_csel;
  logic [1:0] m_clk;
  logic [1:0] m_mosi;
  logic       flash_miso;

  always #5 clk = ~clk;

  spi_flash_arbiter_if ifa ();
  spi_flash_arbiter_if ifb ();
  spi_flash_arbiter_if ifc ();

  assign ifa.req = req; assign ifa.m_csel = m_csel; assign ifa.m_clk = m_clk;
  assign ifa.m_mosi = m_mosi; assign ifa.flash_miso = flash_miso;
  assign ifb.req = req; assign ifb.m_csel = m_csel; assign ifb.m_clk = m_clk;
  assign ifb.m_mosi = m_mosi; assign ifb.flash_miso = flash_miso;
  assign ifc.req = req; assign ifc.m_csel = m_csel; assign ifc.m_clk = m_clk;
  assign ifc.m_mosi = m_mosi; assign ifc.flash_miso = flash_miso;

  spi_flash_arbiter #(.CS_GAP_CYCLES(4), .MAX_HOLD_CYCLES(0), .HOLD_WIDTH(24))
    dut_a (.clk_48mhz(clk), .resetn(resetn), .bus(ifa));
  spi_flash_arbiter #(.CS_GAP_CYCLES(4), .MAX_HOLD_CYCLES(100), .HOLD_WIDTH(24))
    dut_b (.clk_48mhz(clk), .resetn(resetn), .bus(ifb));
  spi_flash_arbiter #(.CS_GAP_CYCLES(0), .MAX_HOLD_CYCLES(20), .HOLD_WIDTH(8))
    dut_c (.clk_48mhz(clk), .resetn(resetn), .bus(ifc));

  // {gnt[1:0], busy, timeout, flash_csel, flash_clk, flash_mosi, m_miso[1:0]}
  logic [8:0] obs [3];
  assign obs[0] = {ifa.gnt, ifa.busy, ifa.timeout, ifa.flash_csel, ifa.flash_clk, ifa.flash_mosi, ifa.m_miso};
  assign obs[1] = {ifb.gnt, ifb.busy, ifb.timeout, ifb.flash_csel, ifb.flash_clk, ifb.flash_mosi, ifb.m_miso};
  assign obs[2] = {ifc.gnt, ifc.busy, ifc.timeout, ifc.flash_csel, ifc.flash_clk, ifc.flash_mosi, ifc.m_miso};

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int to_seen [3] = '{0, 0, 0};
  logic [26:0] exp_q [$];

  // Event model: who owns the bus, how long it has held it, how much CS gap is left.
  int gap_len  [3] = '{4, 4, 1};
  int max_hold [3] = '{0, 100, 20};
  int mo_owner [3] = '{-1, -1, -1};
  int mo_held  [3] = '{0, 0, 0};
  int mo_gap   [3] = '{0, 0, 0};
  int mo_prev  [3] = '{1, 1, 1};
  bit mo_lock  [3][2];
  bit mo_to    [3];

  task automatic model_step(input int d);
    int freed;
    bit want0, want1;
    freed = -1;
    if (!resetn) begin
      mo_owner[d] = -1; mo_gap[d] = 0; mo_prev[d] = 1;
      mo_lock[d][0] = 0; mo_lock[d][1] = 0; mo_to[d] = 0;
      return;
    end
    mo_to[d] = 0;
    if (mo_owner[d] >= 0) begin
      mo_held[d] = mo_held[d] + 1;
      if (!req[mo_owner[d]]) begin
        mo_owner[d] = -1;
        mo_gap[d]   = gap_len[d];
      end else if (max_hold[d] != 0 && mo_held[d] == max_hold[d]) begin
        mo_to[d]    = 1;
        freed       = mo_owner[d];
        mo_owner[d] = -1;
        mo_gap[d]   = gap_len[d];
      end
    end else if (mo_gap[d] > 0) begin
      mo_gap[d] = mo_gap[d] - 1;
    end else begin
      want0 = req[0] && !mo_lock[d][0];
      want1 = req[1] && !mo_lock[d][1];
      if (want0 || want1) begin
        if (want0 && want1) mo_owner[d] = 1 - mo_prev[d];
        else                mo_owner[d] = want1 ? 1 : 0;
        mo_held[d] = 0;
        mo_prev[d] = mo_owner[d];
      end
    end
    for (int i = 0; i < 2; i++) if (!req[i]) mo_lock[d][i] = 0;
    if (freed >= 0) mo_lock[d][freed] = 1;
  endtask

  function automatic logic [8:0] expected(input int d);
    int o;
    logic [1:0] g, miso;
    logic busy, cs, ck, mo;
    o    = mo_owner[d];
    busy = (o >= 0) || (mo_gap[d] > 0);
    if (o >= 0) begin
      g    = (o == 1) ? 2'b10 : 2'b01;
      cs   = m_csel[o]; ck = m_clk[o]; mo = m_mosi[o];
      miso = (o == 1) ? {flash_miso, 1'b1} : {1'b1, flash_miso};
    end else begin
      g = 2'b00; cs = 1'b1; ck = 1'b0; mo = 1'b0; miso = 2'b11;
    end
    return {g, busy, mo_to[d], cs, ck, mo, miso};
  endfunction

  task automatic cyc(input logic [1:0] r, input logic rn);
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_step(d);
    #1;
    req        = r;
    resetn     = rn;
    m_csel     = 2'($urandom);
    m_clk      = 2'($urandom);
    m_mosi     = 2'($urandom);
    flash_miso = 1'($urandom);
    exp_q.push_back({expected(2), expected(1), expected(0)});
    cycle++;
  endtask

  logic [26:0] ent;
  logic [8:0]  exp_v;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      for (int d = 0; d < 3; d++) begin
        exp_v = ent[d*9 +: 9];
        checks++;
        if (obs[d] !== exp_v) begin
          errors++;
          $display("FAIL outputs dut%0d cycle %0d: got %b want %b", d, cycle, obs[d], exp_v);
        end
        checks++;
        if ($countones(obs[d][8:7]) > 1) begin
          errors++;
          $display("FAIL gnt_onehot dut%0d cycle %0d: got %b want at most one bit", d, cycle, obs[d][8:7]);
        end
        if (obs[d][5] === 1'b1) to_seen[d]++;
      end
    end
  end

  initial begin
    logic [1:0] rr;
    int left [2];
    logic rn;
    resetn = 1'b0; req = 2'b00; m_csel = 2'b11; m_clk = 2'b00; m_mosi = 2'b00; flash_miso = 1'b0;

    cyc(2'b00, 1'b0); cyc(2'b00, 1'b0);
    repeat (8)  cyc(2'b01, 1'b1);   // single requester
    repeat (6)  cyc(2'b11, 1'b1);   // port 1 waits behind port 0
    repeat (3)  cyc(2'b10, 1'b1);   // port 0 releases
    repeat (10) cyc(2'b11, 1'b1);   // port 0 re-requests at once
    repeat (10) cyc(2'b01, 1'b1);
    repeat (8)  cyc(2'b00, 1'b1);
    cyc(2'b00, 1'b0);
    repeat (3)  cyc(2'b11, 1'b1);   // tie straight out of reset
    repeat (8)  cyc(2'b10, 1'b1);
    repeat (8)  cyc(2'b00, 1'b1);
    repeat (6)  cyc(2'b01, 1'b1);   // reset lands mid-transfer
    cyc(2'b01, 1'b0);
    repeat (5)  cyc(2'b01, 1'b1);
    repeat (8)  cyc(2'b00, 1'b1);
    repeat (30) cyc(2'b10, 1'b1);   // long hold trips the watchdogs
    repeat (90) cyc(2'b11, 1'b1);
    repeat (12) cyc(2'b10, 1'b1);
    cyc(2'b00, 1'b1);
    repeat (10) cyc(2'b10, 1'b1);
    repeat (10) cyc(2'b00, 1'b1);
    repeat (20) cyc(2'b01, 1'b1);   // release coincides with 20-cycle expiry
    repeat (10) cyc(2'b00, 1'b1);
    repeat (21) cyc(2'b01, 1'b1);   // one cycle longer: expiry wins
    repeat (10) cyc(2'b00, 1'b1);

    rr = 2'b00; left[0] = 0; left[1] = 0;
    repeat (4000) begin
      for (int i = 0; i < 2; i++) begin
        if (left[i] == 0) begin
          rr[i]   = ~rr[i];
          left[i] = rr[i] ? int'($urandom_range(1, 130)) : int'($urandom_range(1, 12));
        end
        left[i]--;
      end
      rn = ($urandom_range(0, 799) != 0);
      cyc(rr, rn);
    end
    repeat (3) cyc(2'b00, 1'b1);
    @(negedge clk); #1;

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    checks++;
    if (to_seen[1] == 0) begin
      errors++;
      $display("FAIL timeout_seen_b: got %0d pulses want nonzero", to_seen[1]);
    end
    checks++;
    if (to_seen[2] == 0) begin
      errors++;
      $display("FAIL timeout_seen_c: got %0d pulses want nonzero", to_seen[2]);
    end
    checks++;
    if (to_seen[0] != 0) begin
      errors++;
      $display("FAIL timeout_disabled_a: got %0d pulses want 0", to_seen[0]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
